// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Turns the raw board reset and the PLL lock indication into staged,
// synchronously released subsystem resets. After the synchronized reset
// deasserts, the sequencer waits HOLD_CYCLES, then waits for LOCK_STABLE
// consecutive cycles of synchronized lock. It then releases rst_out[0],
// rst_out[1], ... with STAGE_GAP cycles between releases. When the last
// stage is released the block enters RUN and raises ready.
//
// Loss of lock (in STAGE or RUN), a software request (RUN only) or an
// optional watchdog timeout sends the block back to HOLD. The reason is
// latched in reset_cause.
//
// Optional feature macro: RESET_SEQ_WDOG_EN
//   defined   : RUN-state watchdog, cleared by wdog_kick, cause 2'b11
//   undefined : no watchdog logic, wdog_kick unused
//
// Ports
//   clk          in   system clock
//   rst          in   async active-high reset; deassertion synchronized here
//   pll_locked   in   async PLL lock status, synchronized here
//   sw_reset_req in   single-cycle software reset request (honoured in RUN)
//   wdog_kick    in   watchdog kick (watchdog build only)
//   rst_out      out  [N_STAGES] active-high stage resets, bit 0 first
//   ready        out  high only in RUN
//   reset_cause  out  [2] 00 ext, 01 lock loss, 10 software, 11 watchdog
// -----------------------------------------------------------------------------
`default_nettype none

module reset_sequencer #(
  parameter int N_STAGES    = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int LOCK_STABLE = 8,
  parameter int STAGE_GAP   = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic                sw_reset_req,
  input  logic                wdog_kick,
  output logic [N_STAGES-1:0] rst_out,
  output logic                ready,
  output logic [1:0]          reset_cause
);

  // One shared down-the-line counter serves HOLD, WAIT_LOCK and STAGE, so it
  // is sized for the longest of the three intervals.
  localparam int CNT_MAX0 = (HOLD_CYCLES > LOCK_STABLE) ? HOLD_CYCLES : LOCK_STABLE;
  localparam int CNT_MAX  = (CNT_MAX0 > STAGE_GAP) ? CNT_MAX0 : STAGE_GAP;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int IDX_W    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  // Index of the stage whose gap expiry releases the final stage.
  localparam int LAST_IDX = (N_STAGES > 1) ? (N_STAGES - 2) : 0;
  localparam int WDOG_W   = $clog2(WDOG_CYCLES + 1);

  localparam logic [1:0] CAUSE_EXT  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;
  localparam logic [1:0] CAUSE_WDOG = 2'b11;

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STAGE     = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] rst_chain_r;
  logic [SYNC_STAGES-1:0] lock_chain_r;
  logic                   rst_sync_s;
  logic                   lock_s;

  state_t                 state_r, state_n;
  logic [CNT_W-1:0]       cnt_r, cnt_n;
  logic [IDX_W-1:0]       idx_r, idx_n;
  logic [N_STAGES-1:0]    rst_out_r, rst_out_n;
  logic                   ready_r, ready_n;
  logic [1:0]             cause_r, cause_n;

  logic                   lock_ev_s;
  logic                   sw_ev_s;
  logic                   wdog_ev_s;
  logic                   any_ev_s;

  // Reset synchronizer: asserts immediately with rst, releases after SYNC_STAGES edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_chain_r <= '1;
    end else begin
      rst_chain_r <= {rst_chain_r[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync_s = rst_chain_r[SYNC_STAGES-1];

  // Lock synchronizer: brings the asynchronous pll_locked into the clk domain.
  always_ff @(posedge clk or posedge rst_sync_s) begin
    if (rst_sync_s) begin
      lock_chain_r <= '0;
    end else begin
      lock_chain_r <= {lock_chain_r[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign lock_s = lock_chain_r[SYNC_STAGES-1];

  // Lock loss only matters once stages have started releasing; software
  // requests are honoured only once the whole system is up.
  assign lock_ev_s = ((state_r == ST_STAGE) || (state_r == ST_RUN)) && !lock_s;
  assign sw_ev_s   = (state_r == ST_RUN) && sw_reset_req;
  assign any_ev_s  = lock_ev_s || wdog_ev_s || sw_ev_s;

`ifdef RESET_SEQ_WDOG_EN
  // The event fires on the edge where the count would reach WDOG_CYCLES-1.
  localparam int WDOG_LAST = (WDOG_CYCLES >= 2) ? (WDOG_CYCLES - 2) : 0;

  logic [WDOG_W-1:0] wdog_cnt_r, wdog_cnt_n;

  assign wdog_ev_s = (state_r == ST_RUN) && !wdog_kick &&
                     (wdog_cnt_r == WDOG_W'(WDOG_LAST));

  // Watchdog next count: runs only in RUN, cleared by a kick or any event.
  always_comb begin
    wdog_cnt_n = '0;
    if ((state_r == ST_RUN) && !any_ev_s && !wdog_kick) begin
      wdog_cnt_n = wdog_cnt_r + WDOG_W'(1'b1);
    end else begin
      wdog_cnt_n = '0;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge rst_sync_s) begin
    if (rst_sync_s) begin
      wdog_cnt_r <= '0;
    end else begin
      wdog_cnt_r <= wdog_cnt_n;
    end
  end
`else
  logic [WDOG_W-1:0] wdog_unused_s;

  assign wdog_ev_s     = 1'b0;
  assign wdog_unused_s = {WDOG_W{wdog_kick}};
`endif

  // Sequencer next-state and next-output logic.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    idx_n     = idx_r;
    rst_out_n = rst_out_r;
    ready_n   = ready_r;
    cause_n   = cause_r;

    if (any_ev_s) begin
      state_n   = ST_HOLD;
      cnt_n     = '0;
      idx_n     = '0;
      rst_out_n = '1;
      ready_n   = 1'b0;
      if (lock_ev_s) begin
        cause_n = CAUSE_LOCK;
      end else if (wdog_ev_s) begin
        cause_n = CAUSE_WDOG;
      end else begin
        cause_n = CAUSE_SW;
      end
    end else begin
      case (state_r)
        ST_HOLD: begin
          rst_out_n = '1;
          ready_n   = 1'b0;
          if (cnt_r == CNT_W'(HOLD_CYCLES - 1)) begin
            state_n = ST_WAIT_LOCK;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_r + CNT_W'(1'b1);
          end
        end

        ST_WAIT_LOCK: begin
          if (lock_s) begin
            if (cnt_r == CNT_W'(LOCK_STABLE - 1)) begin
              // Stage 0 is released on the same edge the lock qualifies.
              cnt_n     = '0;
              idx_n     = '0;
              rst_out_n = rst_out_r << 1'b1;
              if (N_STAGES == 1) begin
                state_n = ST_RUN;
                ready_n = 1'b1;
              end else begin
                state_n = ST_STAGE;
              end
            end else begin
              cnt_n = cnt_r + CNT_W'(1'b1);
            end
          end else begin
            cnt_n = '0;
          end
        end

        ST_STAGE: begin
          if (cnt_r == CNT_W'(STAGE_GAP - 1)) begin
            // Shifting a zero in from the bottom releases the next stage
            // while keeping earlier ones released and later ones held.
            cnt_n     = '0;
            idx_n     = idx_r + IDX_W'(1'b1);
            rst_out_n = rst_out_r << 1'b1;
            if (idx_r == IDX_W'(LAST_IDX)) begin
              state_n = ST_RUN;
              ready_n = 1'b1;
            end else begin
              state_n = ST_STAGE;
            end
          end else begin
            cnt_n = cnt_r + CNT_W'(1'b1);
          end
        end

        ST_RUN: begin
          ready_n = 1'b1;
        end

        default: begin
          state_n   = ST_HOLD;
          cnt_n     = '0;
          idx_n     = '0;
          rst_out_n = '1;
          ready_n   = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state and output registers, reset by the synchronized reset.
  always_ff @(posedge clk or posedge rst_sync_s) begin
    if (rst_sync_s) begin
      state_r   <= ST_HOLD;
      cnt_r     <= '0;
      idx_r     <= '0;
      rst_out_r <= '1;
      ready_r   <= 1'b0;
      cause_r   <= CAUSE_EXT;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      idx_r     <= idx_n;
      rst_out_r <= rst_out_n;
      ready_r   <= ready_n;
      cause_r   <= cause_n;
    end
  end

  assign rst_out     = rst_out_r;
  assign ready       = ready_r;
  assign reset_cause = cause_r;

endmodule

`default_nettype wire
